r2sdf_butterfly_stage: RTL and testbench
========================================

Name: r2sdf_butterfly_stage

Overview:
Radix-2 single-delay-feedback (R2SDF) butterfly stage for the streaming 1024-point FFT. It is the consumer of a per-stage twiddle/control ROM, which supplies the `state` code plus twiddle `w_r`/`w_i`. The block holds the first half of each butterfly group in a feedback delay line and emits sums directly. It emits differences later, after multiplying them by the twiddle. One complex sample enters per cycle and one complex sample leaves per cycle.

Parameters:
DATA_W, 24, width of each real/imag data word and each twiddle word (two's complement, Q16.8).
TW_FRAC, 8, twiddle fractional bits (twiddle 1.0 = 256, -1.0 = 0xFFFF00).
DELAY, 2, feedback delay-line depth in complex words (N/2 of this stage's butterfly span).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  din_r/din_i carry a sample this cycle
din_r  in  DATA_W  input sample, real part
din_i  in  DATA_W  input sample, imaginary part
state  in  2  stage control from twiddle ROM: 0 fill, 1 butterfly, 2 twiddle-out, 3 reserved
w_r  in  DATA_W  twiddle real part, valid in the same cycle as state
w_i  in  DATA_W  twiddle imaginary part, valid in the same cycle as state
dout_r  out  DATA_W  output sample, real part (registered)
dout_i  out  DATA_W  output sample, imaginary part (registered)
out_valid  out  1  dout_r/dout_i valid (registered)

Behaviour:
- Clock and reset: clk is the clock. rst_n is asynchronous and active-low.
- Reset values: the delay line (DELAY complex entries), dout_r, dout_i and out_valid are all cleared to 0.
- Delay line: FIFO shift register with head = oldest entry, tail = newest.
  - It advances, pushing one word and dropping the head, on every cycle where en = in_valid | (state==1) | (state==2).
  - When en=0, all contents hold.
- Per-state action, computed combinationally from head H and input D=(din_r,din_i), registered on the next edge:
  - state 0 (fill):
    - push D, drop head.
    - out_valid <= 0; dout holds its previous value.
    - If in_valid=0, nothing moves.
  - state 1 (butterfly):
    - dout <= H + D.
    - push H - D.
    - out_valid <= 1.
  - state 2 (twiddle-out):
    - dout <= H * W, where W = w_r + j*w_i.
    - push D.
    - out_valid <= 1.
  - state 3: treated as state 0 (fill), no output.
- Latency: 1 cycle from the state/din cycle to the dout/out_valid cycle.
- A full-group result order, for DELAY=2 with ROM sequence 0,0,1,1,2,2,1,1,...: sums of the current group interleave with twiddled differences of the previous group.
- Add/sub: DATA_W-bit two's complement, no growth, no scaling, wrap on overflow (0x7FFFFF + 1 = 0x800000).
- Complex multiply:
  - Products are full 2*DATA_W signed.
  - re = w_r*Hr - w_i*Hi; im = w_r*Hi + w_i*Hr.
  - Each result is arithmetic-shifted right by TW_FRAC (floor toward -inf).
  - Keep bits [TW_FRAC+DATA_W-1 : TW_FRAC]; upper bits are discarded (wrap, no saturation).
- Flush: after the final input, upstream keeps driving state with din=0. The stage needs no in_valid to drain, since state 1/2 alone enables shifting.
- Reset mid-operation: all contents and outputs clear immediately. The partial group is lost. There is no recovery of the in-flight group.
- Simultaneous events: in_valid is don't-care in states 1/2; the shift is unconditional.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with out_valid=1 -> dout_r=dout_i=0 and out_valid=0 immediately (async). After release, the first state-1 output equals D + 0.
2. Basic butterfly, DELAY=2:
   - Stimulus: real inputs 256, 512, 768, 1024 (1.0, 2.0, 3.0, 4.0) with states 0,0,1,1. Then states 2,2 with twiddles (256,0) and (0,0xFFFF00), and din=0.
   - Required outputs (one cycle after each), in order: (1024,0), (1536,0), (-512,0), (0,512).
3. Fill hold: state=0 with in_valid toggling 1,0,1 -> only two pushes occur, and the next state-1 cycle uses the first-pushed word as head; out_valid stays 0 throughout fill.
4. Multiply rounding: H=(-1,0) raw, W=(128,0) -> dout_r=-1 (floor of -0.5 LSB). H=(1,0), W=(128,0) -> dout_r=0.
5. Wrap arithmetic: H=(0x7FFFFF,0), D=(1,0) in state 1 -> dout_r=0x800000, and pushed difference = 0x7FFFFE.
6. Continuous stream: 1024 random samples with ROM-driven state, compared against a bit-accurate model. Required: every output matches, and out_valid is high exactly when the previous-cycle state was 1 or 2.

Source files
------------

// File: rtl/r2sdf_butterfly_stage_if.sv
// Streaming sample/control bus between the twiddle ROM, upstream FFT stage and
// one R2SDF butterfly stage.
interface r2sdf_butterfly_stage_if #(
  parameter int unsigned DATA_W = 24
);
  logic              in_valid;
  logic [DATA_W-1:0] din_r;
  logic [DATA_W-1:0] din_i;
  logic [1:0]        state;
  logic [DATA_W-1:0] w_r;
  logic [DATA_W-1:0] w_i;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] dout_i;
  logic              out_valid;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  dout_r, dout_i, out_valid
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output dout_r, dout_i, out_valid
  );
endinterface

// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-delay-feedback butterfly stage: sums leave immediately,
// differences recirculate through the delay line and leave twiddled later.
module r2sdf_butterfly_stage #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TW_FRAC = 8,
  parameter int unsigned DELAY   = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  r2sdf_butterfly_stage_if.slave bus
);

  localparam int unsigned PW = 2 * DATA_W;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;

  logic [DATA_W-1:0] dl_r_q [DELAY];
  logic [DATA_W-1:0] dl_i_q [DELAY];
  logic [DATA_W-1:0] dl_r_d [DELAY];
  logic [DATA_W-1:0] dl_i_d [DELAY];

  logic [DATA_W-1:0] dout_r_q, dout_r_d;
  logic [DATA_W-1:0] dout_i_q, dout_i_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] head_r, head_i;
  logic [DATA_W-1:0] push_r, push_i;
  logic [DATA_W-1:0] mul_r, mul_i;
  logic signed [PW-1:0] re_full, im_full;
  logic              shift_en;

  function automatic logic signed [PW-1:0] sext(input logic [DATA_W-1:0] v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  assign head_r = dl_r_q[0];
  assign head_i = dl_i_q[0];

  // Full-precision complex product, floored by TW_FRAC, wrapped to DATA_W.
  always_comb begin
    re_full = sext(bus.w_r) * sext(head_r) - sext(bus.w_i) * sext(head_i);
    im_full = sext(bus.w_r) * sext(head_i) + sext(bus.w_i) * sext(head_r);
    mul_r   = DATA_W'(re_full >>> TW_FRAC);
    mul_i   = DATA_W'(im_full >>> TW_FRAC);
  end

  always_comb begin
    dl_r_d      = dl_r_q;
    dl_i_d      = dl_i_q;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    out_valid_d = 1'b0;
    push_r      = bus.din_r;
    push_i      = bus.din_i;
    shift_en    = bus.in_valid | (bus.state == ST_BFLY) | (bus.state == ST_TWID);

    case (bus.state)
      ST_BFLY: begin
        dout_r_d    = head_r + bus.din_r;
        dout_i_d    = head_i + bus.din_i;
        push_r      = head_r - bus.din_r;
        push_i      = head_i - bus.din_i;
        out_valid_d = 1'b1;
      end
      ST_TWID: begin
        dout_r_d    = mul_r;
        dout_i_d    = mul_i;
        out_valid_d = 1'b1;
      end
      ST_FILL: ;
      default: ;
    endcase

    // Head is index 0; new word enters at the tail.
    if (shift_en) begin
      for (int unsigned i = 0; i < DELAY - 1; i++) begin
        dl_r_d[i] = dl_r_q[i+1];
        dl_i_d[i] = dl_i_q[i+1];
      end
      dl_r_d[DELAY-1] = push_r;
      dl_i_d[DELAY-1] = push_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        dl_r_q[i] <= '0;
        dl_i_q[i] <= '0;
      end
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dl_r_q      <= dl_r_d;
      dl_i_q      <= dl_i_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Bench for r2sdf_butterfly_stage: directed scenarios plus a randomized
// stream compared against a queue-based model of the stage.
module tb_r2sdf_butterfly_stage;

  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TW_FRAC = 8;
  localparam int unsigned DELAY   = 2;

  logic clk;
  logic rst_n;

  r2sdf_butterfly_stage_if #(.DATA_W(DATA_W)) bus ();

  r2sdf_butterfly_stage #(
    .DATA_W (DATA_W),
    .TW_FRAC(TW_FRAC),
    .DELAY  (DELAY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Model: delay line as a queue (front = oldest) plus expected output regs.
  logic [DATA_W-1:0] mq_r[$];
  logic [DATA_W-1:0] mq_i[$];
  logic [DATA_W-1:0] exp_r, exp_i;
  logic              exp_v;

  task automatic model_reset();
    mq_r.delete();
    mq_i.delete();
    for (int i = 0; i < DELAY; i++) begin
      mq_r.push_back('0);
      mq_i.push_back('0);
    end
    exp_r = '0;
    exp_i = '0;
    exp_v = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [1:0] st,
                            input logic [DATA_W-1:0] dr, input logic [DATA_W-1:0] di,
                            input logic [DATA_W-1:0] wr, input logic [DATA_W-1:0] wi);
    logic [DATA_W-1:0] hr, hi, pr, pi;
    longint shr, shi, swr, swi, re, im;
    hr = mq_r[0];
    hi = mq_i[0];
    pr = dr;
    pi = di;
    exp_v = 1'b0;
    if (st == 2'd1) begin
      exp_r = hr + dr;
      exp_i = hi + di;
      pr    = hr - dr;
      pi    = hi - di;
      exp_v = 1'b1;
    end else if (st == 2'd2) begin
      shr = $signed(hr);
      shi = $signed(hi);
      swr = $signed(wr);
      swi = $signed(wi);
      re  = swr * shr - swi * shi;
      im  = swr * shi + swi * shr;
      exp_r = DATA_W'(re >>> TW_FRAC);
      exp_i = DATA_W'(im >>> TW_FRAC);
      exp_v = 1'b1;
    end
    if (iv || st == 2'd1 || st == 2'd2) begin
      void'(mq_r.pop_front());
      void'(mq_i.pop_front());
      mq_r.push_back(pr);
      mq_i.push_back(pi);
    end
  endtask

  // Apply one cycle of stimulus; returns #1 after the capturing edge.
  task automatic drive(input logic iv, input logic [1:0] st,
                       input logic [DATA_W-1:0] dr, input logic [DATA_W-1:0] di,
                       input logic [DATA_W-1:0] wr, input logic [DATA_W-1:0] wi);
    bus.in_valid = iv;
    bus.state    = st;
    bus.din_r    = dr;
    bus.din_i    = di;
    bus.w_r      = wr;
    bus.w_i      = wi;
    model_step(iv, st, dr, di, wr, wi);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.state    = 2'd0;
    bus.din_r    = '0;
    bus.din_i    = '0;
    bus.w_r      = '0;
    bus.w_i      = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++; if (bus.dout_r !== 24'd0) $display("FAIL reset_dout_r got=%h exp=0", bus.dout_r); else n_pass++;
    n_chk++; if (bus.dout_i !== 24'd0) $display("FAIL reset_dout_i got=%h exp=0", bus.dout_i); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b1, 2'd1, 24'd5, 24'd7, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b1 || bus.dout_r !== 24'd5 || bus.dout_i !== 24'd7)
      $display("FAIL pre_reset_out got=%b %h %h exp=1 5 7", bus.out_valid, bus.dout_r, bus.dout_i); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.dout_r !== 24'd0 || bus.dout_i !== 24'd0)
      $display("FAIL async_reset got=%b %h %h exp=0 0 0", bus.out_valid, bus.dout_r, bus.dout_i); else n_pass++;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 2'd1, 24'd3, 24'd4, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b1 || bus.dout_r !== 24'd3 || bus.dout_i !== 24'd4)
      $display("FAIL post_reset_first got=%b %h %h exp=1 3 4", bus.out_valid, bus.dout_r, bus.dout_i); else n_pass++;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] er [4];
    logic [DATA_W-1:0] ei [4];
    er[0] = 24'd1024;        ei[0] = 24'd0;
    er[1] = 24'd1536;        ei[1] = 24'd0;
    er[2] = -24'sd512;       ei[2] = 24'd0;
    er[3] = 24'd0;           ei[3] = 24'd512;
    apply_reset();
    drive(1'b1, 2'd0, 24'd256, 24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL basic_fill0_valid got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b1, 2'd0, 24'd512, 24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL basic_fill1_valid got=%b exp=0", bus.out_valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(1'b1, 2'd1, 24'd768,  24'd0, 24'd0,   24'd0);
        1: drive(1'b1, 2'd1, 24'd1024, 24'd0, 24'd0,   24'd0);
        2: drive(1'b0, 2'd2, 24'd0,    24'd0, 24'd256, 24'd0);
        default: drive(1'b0, 2'd2, 24'd0, 24'd0, 24'd0, 24'hFFFF00);
      endcase
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.dout_r !== er[k] || bus.dout_i !== ei[k])
        $display("FAIL basic_out%0d got=%b (%h,%h) exp=1 (%h,%h)", k, bus.out_valid, bus.dout_r, bus.dout_i, er[k], ei[k]);
      else n_pass++;
    end
  endtask

  task automatic test_fill_hold();
    apply_reset();
    drive(1'b1, 2'd0, 24'd100, 24'd1, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL fill_valid0 got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b0, 2'd0, 24'd999, 24'd9, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL fill_valid1 got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b1, 2'd0, 24'd200, 24'd2, 24'd0, 24'd0);
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL fill_valid2 got=%b exp=0", bus.out_valid); else n_pass++;
    drive(1'b0, 2'd1, 24'd0, 24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.dout_r !== 24'd100 || bus.dout_i !== 24'd1)
      $display("FAIL fill_head0 got=(%h,%h) exp=(64,1)", bus.dout_r, bus.dout_i); else n_pass++;
    drive(1'b0, 2'd1, 24'd0, 24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.dout_r !== 24'd200 || bus.dout_i !== 24'd2)
      $display("FAIL fill_head1 got=(%h,%h) exp=(c8,2)", bus.dout_r, bus.dout_i); else n_pass++;
  endtask

  task automatic test_rounding();
    apply_reset();
    drive(1'b1, 2'd0, 24'hFFFFFF, 24'd0, 24'd0, 24'd0);
    drive(1'b1, 2'd0, 24'd1,      24'd0, 24'd0, 24'd0);
    drive(1'b0, 2'd2, 24'd0, 24'd0, 24'd128, 24'd0);
    n_chk++; if (bus.dout_r !== 24'hFFFFFF || bus.dout_i !== 24'd0)
      $display("FAIL round_neg got=(%h,%h) exp=(ffffff,0)", bus.dout_r, bus.dout_i); else n_pass++;
    drive(1'b0, 2'd2, 24'd0, 24'd0, 24'd128, 24'd0);
    n_chk++; if (bus.dout_r !== 24'd0 || bus.dout_i !== 24'd0)
      $display("FAIL round_pos got=(%h,%h) exp=(0,0)", bus.dout_r, bus.dout_i); else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(1'b1, 2'd0, 24'h7FFFFF, 24'd0, 24'd0, 24'd0);
    drive(1'b1, 2'd0, 24'd0,      24'd0, 24'd0, 24'd0);
    drive(1'b1, 2'd1, 24'd1,      24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.dout_r !== 24'h800000)
      $display("FAIL wrap_sum got=%h exp=800000", bus.dout_r); else n_pass++;
    drive(1'b0, 2'd1, 24'd0, 24'd0, 24'd0, 24'd0);
    drive(1'b0, 2'd1, 24'd0, 24'd0, 24'd0, 24'd0);
    n_chk++; if (bus.dout_r !== 24'h7FFFFE)
      $display("FAIL wrap_diff got=%h exp=7ffffe", bus.dout_r); else n_pass++;
  endtask

  task automatic test_stream();
    logic [1:0] st, prev_st;
    logic       iv;
    int         errs;
    apply_reset();
    prev_st = 2'd0;
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k < DELAY) st = 2'd0;
      else st = (((k - DELAY) / DELAY) % 2 == 0) ? 2'd1 : 2'd2;
      if ($urandom_range(0, 19) == 0) st = 2'($urandom_range(0, 3));
      iv = 1'($urandom_range(0, 1));
      drive(iv, st, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom));
      n_chk++;
      if (bus.out_valid !== exp_v || bus.dout_r !== exp_r || bus.dout_i !== exp_i) begin
        if (errs < 10)
          $display("FAIL stream_out k=%0d got=%b (%h,%h) exp=%b (%h,%h)", k,
                   bus.out_valid, bus.dout_r, bus.dout_i, exp_v, exp_r, exp_i);
        errs++;
      end else n_pass++;
      n_chk++;
      if (bus.out_valid !== (st == 2'd1 || st == 2'd2)) begin
        if (errs < 10)
          $display("FAIL stream_valid k=%0d got=%b state=%0d", k, bus.out_valid, st);
        errs++;
      end else n_pass++;
      prev_st = st;
    end
    // Flush with din=0 and no in_valid; sums/differences must still drain.
    for (int k = 0; k < 4 * DELAY; k++) begin
      st = ((k / DELAY) % 2 == 0) ? 2'd1 : 2'd2;
      drive(1'b0, st, '0, '0, DATA_W'($urandom), DATA_W'($urandom));
      n_chk++;
      if (bus.out_valid !== exp_v || bus.dout_r !== exp_r || bus.dout_i !== exp_i)
        $display("FAIL flush_out k=%0d got=%b (%h,%h) exp=%b (%h,%h) prev_state=%0d", k,
                 bus.out_valid, bus.dout_r, bus.dout_i, exp_v, exp_r, exp_i, prev_st);
      else n_pass++;
      prev_st = st;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    test_reset();
    test_basic();
    test_fill_hold();
    test_rounding();
    test_wrap();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
